// File: rtl/apurador_votos_if.sv
// Bus between the control unit and the vote tallier (apurador_votos).
// Handshake: voto_en, morra and mata_noite are single-cycle strobes that
// qualify their data in the same cycle. There is no ready/backpressure.
// The tallier samples each strobe on the rising edge where it is high.
// A vote it cannot take is dropped without any indication.
// votou is a level that stays high while a finished tally is on
// eliminado/eliminado_valido/acertou.
interface apurador_votos_if;
  logic       votacao;
  logic       voto_en;
  logic [2:0] voto_origem;
  logic [2:0] voto_alvo;
  logic       morra;
  logic       mata_noite;
  logic [2:0] alvo_noite;
  logic [2:0] lobo_id;
  logic [2:0] jogador_atual;
  logic       votou;
  logic       acertou;
  logic [2:0] eliminado;
  logic       eliminado_valido;
  logic       jogador_vivo;
  logic       sinal_lobo_ganhou;
  logic [4:0] vivos;
  logic [1:0] estado_dbg;

  // Control unit side
  modport master (
    output votacao, voto_en, voto_origem, voto_alvo, morra, mata_noite,
           alvo_noite, lobo_id, jogador_atual,
    input  votou, acertou, eliminado, eliminado_valido, jogador_vivo,
           sinal_lobo_ganhou, vivos, estado_dbg
  );

  // Tallier side
  modport slave (
    input  votacao, voto_en, voto_origem, voto_alvo, morra, mata_noite,
           alvo_noite, lobo_id, jogador_atual,
    output votou, acertou, eliminado, eliminado_valido, jogador_vivo,
           sinal_lobo_ganhou, vivos, estado_dbg
  );
endinterface

// File: rtl/apurador_votos.sv
// apurador_votos: collects one vote per living player during the day vote.
// It scans the five tallies for the most voted player and keeps the
// alive mask.
// Build option APURADOR_EMPATE_ANULA_EN: when it is defined, a tie at the
// maximum count cancels the result. When it is not defined, the lowest
// tied index is eliminated.
module apurador_votos (
  input  logic             clock,
  input  logic             reset,
  apurador_votos_if.slave  bus
);

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    COLETA = 2'd1,
    APURA  = 2'd2,
    PRONTO = 2'd3
  } estado_t;

  estado_t    estado;
  logic [2:0] cnt [5];
  logic [4:0] votado;
  logic [2:0] total;
  logic [2:0] idx;
  logic [2:0] best_cnt;
  logic [2:0] best_idx;
  logic       empate;
  logic [2:0] elim_q;
  logic       valido_q;
  logic       acertou_q;
  logic [4:0] vivos_q;

  // Widened copies so that a 3-bit index can select any bit. Indices 5..7 read as 0.
  logic [7:0] vivos_ext;
  logic [7:0] votado_ext;
  logic [2:0] n_vivos;
  logic       aceita;
  logic       ultimo;

  function automatic logic [2:0] popcount5(input logic [4:0] v);
    logic [2:0] s;
    s = 3'd0;
    for (int i = 0; i < 5; i++) s = s + {2'b00, v[i]};
    return s;
  endfunction

  assign vivos_ext  = {3'b000, vivos_q};
  assign votado_ext = {3'b000, votado};
  assign n_vivos    = popcount5(vivos_q);

  // A vote counts only from a living player who has not voted yet, and only for a living player.
  assign aceita = bus.voto_en && (bus.voto_origem <= 3'd4) && (bus.voto_alvo <= 3'd4) &&
                  vivos_ext[bus.voto_origem] && vivos_ext[bus.voto_alvo] &&
                  !votado_ext[bus.voto_origem];
  assign ultimo = aceita && ((total + 3'd1) == n_vivos);

  logic [2:0] cnt_sel;
  logic [2:0] best_cnt_n;
  logic [2:0] best_idx_n;
  logic       empate_n;

  // One scan step: index 0 seeds the best value. A later index replaces it only on a strictly higher count.
  always_comb begin
    cnt_sel = 3'd0;
    for (int i = 0; i < 5; i++) begin
      if (idx == 3'(i)) cnt_sel = cnt[i];
    end
    best_cnt_n = best_cnt;
    best_idx_n = best_idx;
    empate_n   = empate;
    if (idx == 3'd0) begin
      best_cnt_n = cnt_sel;
      best_idx_n = 3'd0;
      empate_n   = 1'b0;
    end else if (cnt_sel > best_cnt) begin
      best_cnt_n = cnt_sel;
      best_idx_n = idx;
      empate_n   = 1'b0;
    end else if (cnt_sel == best_cnt) begin
      empate_n = 1'b1;
    end
  end

  // Control FSM: collect votes, scan tallies, hold the result until the next round opens.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado    <= OCIOSO;
      for (int i = 0; i < 5; i++) cnt[i] <= 3'd0;
      votado    <= 5'd0;
      total     <= 3'd0;
      idx       <= 3'd0;
      best_cnt  <= 3'd0;
      best_idx  <= 3'd0;
      empate    <= 1'b0;
      elim_q    <= 3'd0;
      valido_q  <= 1'b0;
      acertou_q <= 1'b0;
    end else begin
      case (estado)
        OCIOSO: begin
          for (int i = 0; i < 5; i++) cnt[i] <= 3'd0;
          votado <= 5'd0;
          total  <= 3'd0;
          if (bus.votacao) begin
            estado    <= COLETA;
            elim_q    <= 3'd0;
            valido_q  <= 1'b0;
            acertou_q <= 1'b0;
          end
        end
        COLETA: begin
          if (!bus.votacao) begin
            estado <= OCIOSO;
          end else if (aceita) begin
            for (int i = 0; i < 5; i++) begin
              if (bus.voto_alvo == 3'(i)) cnt[i] <= cnt[i] + 3'd1;
              if (bus.voto_origem == 3'(i)) votado[i] <= 1'b1;
            end
            total <= total + 3'd1;
            if (ultimo) begin
              estado <= APURA;
              idx    <= 3'd0;
            end
          end
        end
        APURA: begin
          best_cnt <= best_cnt_n;
          best_idx <= best_idx_n;
          empate   <= empate_n;
          idx      <= idx + 3'd1;
          if (idx == 3'd4) begin
            estado <= PRONTO;
`ifdef APURADOR_EMPATE_ANULA_EN
            if (empate_n) begin
              elim_q    <= 3'd0;
              valido_q  <= 1'b0;
              acertou_q <= 1'b0;
            end else begin
              elim_q    <= best_idx_n;
              valido_q  <= 1'b1;
              acertou_q <= (best_idx_n == bus.lobo_id);
            end
`else
            elim_q    <= best_idx_n;
            valido_q  <= 1'b1;
            acertou_q <= (best_idx_n == bus.lobo_id);
`endif
          end
        end
        PRONTO: begin
          if (!bus.votacao) estado <= OCIOSO;
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

  logic [4:0] clr_morra;
  logic [4:0] clr_noite;

  // Elimination requests. A night index above 4 matches no bit, so it is ignored.
  always_comb begin
    clr_morra = 5'd0;
    clr_noite = 5'd0;
    for (int i = 0; i < 5; i++) begin
      clr_morra[i] = bus.morra && valido_q && (elim_q == 3'(i));
      clr_noite[i] = bus.mata_noite && (bus.alvo_noite == 3'(i));
    end
  end

  // Alive mask: bits only ever clear. Only reset sets them again.
  always_ff @(posedge clock) begin
    if (reset) vivos_q <= 5'b11111;
    else       vivos_q <= vivos_q & ~(clr_morra | clr_noite);
  end

  assign bus.votou             = (estado == PRONTO);
  assign bus.acertou           = acertou_q;
  assign bus.eliminado         = elim_q;
  assign bus.eliminado_valido  = valido_q;
  assign bus.jogador_vivo      = vivos_ext[bus.jogador_atual];
  assign bus.sinal_lobo_ganhou = (n_vivos <= 3'd2) && vivos_ext[bus.lobo_id];
  assign bus.vivos             = vivos_q;
  assign bus.estado_dbg        = estado;

endmodule

// File: doc/apurador_votos.md
APURADOR_VOTOS -- requirements
Module: apurador_votos

Interface
REQ-001 clock  in  1  system clock; all state changes on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset (driven by rst_global of the control unit).
REQ-003 votacao  in  1  level from control unit, high while in DIA_VOTO.
REQ-004 voto_en  in  1  single-cycle vote strobe.
REQ-005 voto_origem  in  3  voter index 0..4.
REQ-006 voto_alvo  in  3  voted player index 0..4.
REQ-007 morra  in  1  single-cycle pulse; eliminate current eliminado.
REQ-008 mata_noite  in  1  single-cycle pulse; eliminate alvo_noite.
REQ-009 alvo_noite  in  3  night victim index.
REQ-010 lobo_id  in  3  wolf player index, stable during a game.
REQ-011 jogador_atual  in  3  index queried for jogador_vivo.
REQ-012 votou  out  1  tally complete, high only in PRONTO.
REQ-013 acertou  out  1  registered; eliminado_valido and eliminado == lobo_id.
REQ-014 eliminado  out  3  registered most-voted index.
REQ-015 eliminado_valido  out  1  registered; eliminado holds a real result.
REQ-016 jogador_vivo  out  1  vivos[jogador_atual]; 0 for index > 4.
REQ-017 sinal_lobo_ganhou  out  1  popcount(vivos) <= 2 and vivos[lobo_id].
REQ-018 vivos  out  5  alive mask, bit i = player i.

Function
REQ-019 FSM states: OCIOSO, COLETA, APURA, PRONTO; 2-bit state register.
REQ-020 OCIOSO: clear 5 vote counters (3 bits each), voted-mask (5 bits) and vote total; go to COLETA when votacao=1.
REQ-021 On COLETA entry, clear eliminado, eliminado_valido and acertou to 0.
REQ-022 COLETA: accept vote when voto_en=1, origem<=4, alvo<=4, vivos[origem]=1, vivos[alvo]=1, voted-mask[origem]=0; otherwise ignore silently.
REQ-023 Accepted vote: counter[alvo]+1, set voted-mask[origem], total+1, same edge.
REQ-024 COLETA->APURA on the edge accepting the vote that makes total == popcount(vivos); scan index reset to 0.
REQ-025 COLETA->OCIOSO if votacao=0 before completion (abort, no result).
REQ-026 APURA: one index per cycle, 0..4; update best only if counter strictly greater than best count (tie keeps lower index); track tie flag when equal to best.
REQ-027 APURA->PRONTO after index 4; votou high after 5th edge following the edge that accepted the final vote; eliminado, eliminado_valido, acertou registered on that same edge.
REQ-028 PRONTO: votou=1; go to OCIOSO when votacao=0; eliminado/acertou/eliminado_valido held until next COLETA entry.
REQ-029 morra=1 with eliminado_valido=1: clear vivos[eliminado], any state.
REQ-030 mata_noite=1 with alvo_noite<=4: clear vivos[alvo_noite], any state; index > 4 ignored.
REQ-031 morra and mata_noite in same cycle: both clears applied.
REQ-032 Clearing an already-dead bit has no effect; vivos never re-set except by reset.
REQ-033 jogador_vivo, sinal_lobo_ganhou, votou combinational from registers only (no input-to-output path except jogador_atual/lobo_id indexing).

Reset
REQ-034 reset=1 at edge: state=OCIOSO, vivos=5'b11111, counters/mask/total=0, eliminado=0, eliminado_valido=0, acertou=0.
REQ-035 reset overrides every other input, including mid-COLETA or mid-APURA.

Configuration
REQ-036 Macro APURADOR_EMPATE_ANULA_EN.
REQ-037 Defined: tie for maximum count yields eliminado_valido=0, acertou=0, eliminado=0; subsequent morra does nothing.
REQ-038 Not defined: tie resolves to lowest index, eliminado_valido=1.

Verification
REQ-039 Reset, votacao=1, votes (0->2),(1->2),(2->3),(3->2),(4->2) -> votou=1 five edges after last vote, eliminado=2, acertou=1 with lobo_id=2.
REQ-040 Same votes, lobo_id=4 -> acertou=0; morra pulse -> vivos=5'b11011, jogador_vivo=0 for jogador_atual=2.
REQ-041 Duplicate vote from player 1 and vote to dead player -> ignored; total stays, votou only after every alive player votes once.
REQ-042 Tie 2-2-1 on players 1,3,0 -> without macro eliminado=1 valid; with APURADOR_EMPATE_ANULA_EN eliminado_valido=0 and morra leaves vivos unchanged.
REQ-043 mata_noite on 0, 1, then vote-out 3 with lobo_id=4 -> vivos=5'b10100, sinal_lobo_ganhou=1.
REQ-044 reset asserted during APURA -> next cycle OCIOSO, votou=0, vivos=5'b11111.
